// File: rtl/fetch_pkg.sv
// Shared types for the dual-issue fetch sequencer.
// FSM states, issue-count encodings and the held-redirect record.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    DUAL   = 2'd1,
    SINGLE = 2'd2,
    IMWAIT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] ISSUE_NONE = 2'd0;
  localparam logic [1:0] ISSUE_ONE  = 2'd1;
  localparam logic [1:0] ISSUE_TWO  = 2'd2;

  localparam logic SLOT1 = 1'b0;
  localparam logic SLOT2 = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        slot;
    logic [31:0] addr;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Holds a redirect that arrives while instruction memory is stalled.
// A flush load beats a branch load; loads beat clear.
module fetch_redirect_buf
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_ld_flush,
  input  logic [31:0] i_flush_addr,
  input  logic        i_ld_br,
  input  logic        i_br_slot,
  input  logic [31:0] i_br_addr,
  input  logic        i_clr,
  output redirect_t   o_pend
);

  redirect_t r_pend;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pend <= '0;
    end else if (i_ld_flush) begin
      r_pend <= '{valid: 1'b1, slot: SLOT1, addr: i_flush_addr};
    end else if (i_ld_br) begin
      r_pend <= '{valid: 1'b1, slot: i_br_slot, addr: i_br_addr};
    end else if (i_clr) begin
      r_pend <= '0;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Dual-issue fetch sequencer: drives IF-stage controls from decode,
// branch, flush and IM readiness; replays stalled redirects.
module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       issue_cnt,
  input  logic             br_taken1,
  input  logic             br_taken2,
  input  logic [31:0]      br_target,
  input  logic             flush,
  input  logic [31:0]      flush_addr,
  input  logic             imem_ready,
  output logic             single_fetch,
  output logic             fetch_null1,
  output logic             no_new_fetch,
  output logic             freeze,
  output logic             taken_branch1,
  output logic             taken_branch2,
  output logic [31:0]      redirect_addr,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);

  fetch_state_e     r_state;
  fetch_state_e     w_next;
  fetch_state_e     r_resume;
  logic [BW-1:0]    r_boot_cnt;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  redirect_t  w_pend;
  logic [1:0] w_issue;
  logic       w_br;
  logic       w_br_slot;
  logic       w_run;
  logic       w_wait;
  logic       w_stall;
  logic       w_do_fl;
  logic       w_do_br;
  logic       w_do_pd;
  logic       w_redir;
  logic       w_hold;
  logic       w_adv;
  logic       w_boot_done;
  logic [1:0] w_fetch_inc;

  assign w_issue   = (issue_cnt == 2'd3) ? ISSUE_TWO : issue_cnt;
  assign w_br      = br_taken1 | br_taken2;
  assign w_br_slot = br_taken1 ? SLOT1 : SLOT2;
  assign w_run     = (r_state == DUAL) | (r_state == SINGLE);
  assign w_wait    = (r_state == IMWAIT);
  assign w_stall   = (w_run | w_wait) & ~imem_ready;
  assign w_do_fl   = (w_run | w_wait) & imem_ready & flush;
  assign w_do_br   = (w_run | w_wait) & imem_ready & ~flush & w_br;
  assign w_do_pd   = w_wait & imem_ready & ~flush & ~w_br & w_pend.valid;
  assign w_redir   = w_do_fl | w_do_br | w_do_pd;
  assign w_hold    = w_run & imem_ready & ~flush & ~w_br
                   & (w_issue == ISSUE_NONE);
  assign w_adv     = w_run & imem_ready & ~flush & ~w_br
                   & (w_issue != ISSUE_NONE);

  assign w_boot_done = (r_boot_cnt == BW'(BOOT_CYCLES - 1));

  // Redirects seen while IM is stalled are parked, not driven.
  fetch_redirect_buf u_rbuf (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_ld_flush   (w_stall & flush),
    .i_flush_addr (flush_addr),
    .i_ld_br      (w_stall & w_br),
    .i_br_slot    (w_br_slot),
    .i_br_addr    (br_target),
    .i_clr        (w_wait & imem_ready),
    .o_pend       (w_pend)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= BOOT;
      r_resume <= DUAL;
    end else begin
      r_state <= w_next;
      if (w_run & w_stall)
        r_resume <= r_state;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      BOOT: begin
        if (w_boot_done)
          w_next = DUAL;
      end
      IMWAIT: begin
        if (w_redir)
          w_next = DUAL;
        else if (imem_ready)
          w_next = r_resume;
      end
      default: begin
        if (w_stall)
          w_next = IMWAIT;
        else if (w_redir)
          w_next = DUAL;
        else if (w_adv)
          w_next = ((r_state == DUAL) && (w_issue == ISSUE_ONE))
                 ? SINGLE : DUAL;
      end
    endcase
  end

  always_comb begin
    single_fetch  = (r_state == SINGLE) & ~w_redir;
    fetch_null1   = 1'b0;
    no_new_fetch  = (r_state == BOOT) | w_hold;
    freeze        = w_stall;
    taken_branch1 = 1'b0;
    taken_branch2 = 1'b0;
    redirect_addr = '0;
    unique case (1'b1)
      w_do_fl: begin
        taken_branch1 = 1'b1;
        fetch_null1   = 1'b1;
        redirect_addr = flush_addr;
      end
      w_do_br: begin
        taken_branch1 = br_taken1;
        taken_branch2 = ~br_taken1;
        redirect_addr = br_target;
      end
      w_do_pd: begin
        taken_branch1 = (w_pend.slot == SLOT1);
        taken_branch2 = (w_pend.slot == SLOT2);
        redirect_addr = w_pend.addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_fetch_inc = 2'd0;
    if (w_redir)
      w_fetch_inc = w_do_fl ? 2'd1 : 2'd2;
    else if (w_adv)
      w_fetch_inc = (r_state == SINGLE) ? 2'd1 : 2'd2;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_boot_cnt   <= '0;
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_state == BOOT)
        r_boot_cnt <= r_boot_cnt + BW'(1);
      r_fetch_cnt <= r_fetch_cnt + CNT_W'(w_fetch_inc);
      if (no_new_fetch | freeze)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed vector bench for if_fetch_ctrl (4-bit counters so the
// fetch counter wrap is reachable in a short run).
module tb_if_fetch_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [1:0]    issue_cnt = 2'd2;
  logic          br_taken1 = 1'b0;
  logic          br_taken2 = 1'b0;
  logic [31:0]   br_target = '0;
  logic          flush = 1'b0;
  logic [31:0]   flush_addr = '0;
  logic          imem_ready = 1'b1;
  logic          single_fetch;
  logic          fetch_null1;
  logic          no_new_fetch;
  logic          freeze;
  logic          taken_branch1;
  logic          taken_branch2;
  logic [31:0]   redirect_addr;
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  if_fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(CW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .issue_cnt     (issue_cnt),
    .br_taken1     (br_taken1),
    .br_taken2     (br_taken2),
    .br_target     (br_target),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .imem_ready    (imem_ready),
    .single_fetch  (single_fetch),
    .fetch_null1   (fetch_null1),
    .no_new_fetch  (no_new_fetch),
    .freeze        (freeze),
    .taken_branch1 (taken_branch1),
    .taken_branch2 (taken_branch2),
    .redirect_addr (redirect_addr),
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 CLK = ~CLK;

  // eo = {single_fetch, fetch_null1, no_new_fetch, freeze, tb1, tb2}
  typedef struct {
    logic [1:0]    iss;
    logic          b1;
    logic          b2;
    logic [31:0]   tgt;
    logic          fl;
    logic [31:0]   fa;
    logic          rdy;
    logic [5:0]    eo;
    logic [31:0]   ea;
    logic [CW-1:0] ef;
    logic [CW-1:0] eb;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic [1:0] iss, logic b1, logic b2,
                              logic [31:0] tgt, logic fl,
                              logic [31:0] fa, logic rdy,
                              logic [5:0] eo, logic [31:0] ea,
                              logic [CW-1:0] ef, logic [CW-1:0] eb);
    vec_t v;
    v.iss = iss; v.b1 = b1; v.b2 = b2; v.tgt = tgt;
    v.fl = fl; v.fa = fa; v.rdy = rdy;
    v.eo = eo; v.ea = ea; v.ef = ef; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {single_fetch, fetch_null1, no_new_fetch,
            freeze, taken_branch1, taken_branch2};
  endfunction

  task automatic drive(input vec_t v);
    issue_cnt  = v.iss;
    br_taken1  = v.b1;
    br_taken2  = v.b2;
    br_target  = v.tgt;
    flush      = v.fl;
    flush_addr = v.fa;
    imem_ready = v.rdy;
  endtask

  initial begin
    vt[0]  = mk(2, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 0, 0);
    vt[1]  = mk(2, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 0, 1);
    vt[2]  = mk(1, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 2);
    vt[3]  = mk(2, 0, 0, 0, 0, 0, 1, 6'b100000, 0, 2, 2);
    vt[4]  = mk(2, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 3, 2);
    vt[5]  = mk(1, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 5, 2);
    vt[6]  = mk(2, 0, 1, 32'h100, 0, 0, 1, 6'b000001, 32'h100, 7, 2);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 9, 2);
    vt[8]  = mk(2, 0, 0, 0, 0, 0, 0, 6'b000100, 0, 9, 3);
    vt[9]  = mk(2, 1, 0, 32'h200, 0, 0, 0, 6'b000100, 0, 9, 4);
    vt[10] = mk(2, 0, 0, 0, 0, 0, 0, 6'b000100, 0, 9, 5);
    vt[11] = mk(2, 0, 0, 0, 0, 0, 1, 6'b000010, 32'h200, 9, 6);
    vt[12] = mk(2, 1, 0, 32'h300, 1, 32'h80, 1,
                6'b010010, 32'h80, 11, 6);
    vt[13] = mk(1, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 12, 6);
    vt[14] = mk(1, 0, 0, 0, 0, 0, 1, 6'b100000, 0, 14, 6);
    vt[15] = mk(3, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 15, 6);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 1, 6);
    vt[17] = mk(2, 1, 1, 32'h44, 0, 0, 1, 6'b000010, 32'h44, 1, 7);
    vt[18] = mk(2, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 3, 7);

    #3;
    chk("rst_outs", 64'(outs()), 64'(6'b001000));
    chk("rst_addr", 64'(redirect_addr), 64'h0);
    chk("rst_fcnt", 64'(fetch_cnt), 64'h0);
    chk("rst_bcnt", 64'(bubble_cnt), 64'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 19; i++) begin
      if (i > 0) @(negedge CLK);
      drive(vt[i]);
      #4;
      chk($sformatf("v%0d_outs", i), 64'(outs()), 64'(vt[i].eo));
      chk($sformatf("v%0d_addr", i), 64'(redirect_addr), 64'(vt[i].ea));
      chk($sformatf("v%0d_fcnt", i), 64'(fetch_cnt), 64'(vt[i].ef));
      chk($sformatf("v%0d_bcnt", i), 64'(bubble_cnt), 64'(vt[i].eb));
    end

    // Reset while a redirect is parked in IMWAIT.
    @(negedge CLK);
    issue_cnt = 2; imem_ready = 0;
    br_taken1 = 1; br_target = 32'h500;
    #4;
    chk("park_frz", 64'(freeze), 64'h1);
    chk("park_tb1", 64'(taken_branch1), 64'h0);
    @(negedge CLK);
    br_taken1 = 0;
    #2;
    RESET = 1'b0;
    #1;
    chk("mrst_nnf", 64'(no_new_fetch), 64'h1);
    chk("mrst_frz", 64'(freeze), 64'h0);
    chk("mrst_fcnt", 64'(fetch_cnt), 64'h0);
    chk("mrst_bcnt", 64'(bubble_cnt), 64'h0);
    @(negedge CLK);
    RESET = 1'b1; imem_ready = 1;
    repeat (2) @(negedge CLK);
    issue_cnt = 1;
    #4;
    chk("reboot_outs", 64'(outs()), 64'h0);
    chk("reboot_addr", 64'(redirect_addr), 64'h0);
    chk("reboot_bcnt", 64'(bubble_cnt), 64'h2);

    // Stall in SINGLE without a redirect resumes in SINGLE.
    @(negedge CLK);
    issue_cnt = 2; imem_ready = 0;
    #4;
    chk("sstall_outs", 64'(outs()), 64'(6'b100100));
    @(negedge CLK);
    imem_ready = 1; issue_cnt = 0;
    #4;
    chk("sresume_outs", 64'(outs()), 64'h0);
    @(negedge CLK);
    #4;
    chk("sback_outs", 64'(outs()), 64'(6'b101000));
    chk("sback_fcnt", 64'(fetch_cnt), 64'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
